// File: rtl/rs_enc_param.sv
// Systematic Reed-Solomon encoder over GF(2^8) with per-frame shortened length.
// Information symbols pass through unchanged; R parity symbols from an LFSR
// remainder follow them. Valid/ready handshake on both sides; framing errors
// (K_MAX overrun, sop inside a frame) give a one-cycle frame_err pulse.
// Optional feature macro: RS_ENC_BYPASS_EN adds a per-frame 'bypass' input that
// suppresses the parity tail and moves eop onto the last data symbol.
module rs_enc_param #(
  parameter int unsigned R         = 8,
  parameter int unsigned K_MAX     = 8,
  parameter logic [8:0]  PRIM_POLY = 9'h11d,
  parameter int unsigned FCR       = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din_val,
  input  logic       din_sop,
  input  logic       din_eop,
  input  logic [7:0] din,
  output logic       din_rdy,
  output logic       dout_val,
  output logic       dout_sop,
  output logic       dout_eop,
  output logic [7:0] dout,
  input  logic       dout_rdy,
  output logic       frame_err
`ifdef RS_ENC_BYPASS_EN
  ,
  input  logic       bypass
`endif
);

  typedef logic [R:0][7:0] gpoly_t;

  // GF(2^8) multiply, shift-and-add with reduction by the primitive polynomial.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? PRIM_POLY[7:0] : 8'h00);
    end
    return p;
  endfunction

  // Generator g(x) = prod_{i=FCR..FCR+R-1} (x + alpha^i); element j is coefficient of x^j.
  function automatic gpoly_t gen_poly();
    gpoly_t     g;
    logic [7:0] root;
    g    = '0;
    g[0] = 8'h01;
    root = 8'h01;
    for (int unsigned i = 0; i < FCR; i++) root = gf_mul(root, 8'h02);
    for (int unsigned n = 0; n < R; n++) begin
      for (int unsigned j = R; j > 0; j--) g[j] = g[j-1] ^ gf_mul(g[j], root);
      g[0] = gf_mul(g[0], root);
      root = gf_mul(root, 8'h02);
    end
    return g;
  endfunction

  localparam gpoly_t     G       = gen_poly();
  localparam logic [7:0] KMaxC   = 8'(K_MAX);
  localparam logic [5:0] ParLast = 6'(R - 1);

  typedef enum logic [1:0] {StIdle, StData, StParity} state_e;

  state_e             state_q, state_d;
  // Element 0 holds the highest-degree remainder coefficient.
  logic [R-1:0][7:0]  rem_q, rem_d, rem_base, rem_abs;
  logic [7:0]         cnt_q, cnt_d, cnt_inc;
  logic [5:0]         par_q, par_d;
  logic [7:0]         dout_q, dout_d;
  logic               dout_val_q, dout_val_d;
  logic               dout_sop_q, dout_sop_d;
  logic               dout_eop_q, dout_eop_d;
  logic               frame_err_q, frame_err_d;
  logic               adv, accept, start, absorb, forced, last_sym, byp_cur;
  logic [7:0]         fb;

  assign dout      = dout_q;
  assign dout_val  = dout_val_q;
  assign dout_sop  = dout_sop_q;
  assign dout_eop  = dout_eop_q;
  assign frame_err = frame_err_q;

  // Handshake: the output register may load whenever it is empty or being drained.
  assign adv     = !dout_val_q || dout_rdy;
  assign din_rdy = adv && (state_q != StParity);
  assign accept  = din_val && din_rdy;
  assign start   = accept && din_sop;
  assign absorb  = accept && (din_sop || (state_q == StData));

  // Symbol count including the one being accepted; saturates at K_MAX.
  assign cnt_inc  = start ? 8'd1 : ((cnt_q >= KMaxC) ? cnt_q : cnt_q + 8'd1);
  assign forced   = !din_eop && (cnt_inc >= KMaxC);
  assign last_sym = din_eop || forced;

`ifdef RS_ENC_BYPASS_EN
  logic byp_q;
  assign byp_cur = start ? bypass : byp_q;

  // Bypass mode is latched with the sop accept and held for the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_q <= 1'b0;
    end else if (start) begin
      byp_q <= bypass;
    end
  end
`else
  assign byp_cur = 1'b0;
`endif

  // LFSR step for the incoming symbol; a sop restarts from a zero remainder.
  always_comb begin
    rem_base = start ? '0 : rem_q;
    fb       = din ^ rem_base[0];
    for (int unsigned i = 0; i < R - 1; i++) begin
      rem_abs[i] = rem_base[i+1] ^ gf_mul(fb, G[R-1-i]);
    end
    rem_abs[R-1] = gf_mul(fb, G[0]);
  end

  // Next-state and output-register logic; nothing moves unless adv is high.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    par_d       = par_q;
    dout_d      = dout_q;
    dout_val_d  = dout_val_q;
    dout_sop_d  = dout_sop_q;
    dout_eop_d  = dout_eop_q;
    frame_err_d = 1'b0;
    if (adv) begin
      dout_val_d = 1'b0;
      dout_sop_d = 1'b0;
      dout_eop_d = 1'b0;
      unique case (state_q)
        StIdle, StData: begin
          // Non-sop symbols in idle are silently dropped.
          if (absorb) begin
            dout_d      = din;
            dout_val_d  = 1'b1;
            dout_sop_d  = din_sop;
            rem_d       = rem_abs;
            cnt_d       = cnt_inc;
            frame_err_d = forced || ((state_q == StData) && din_sop);
            if (last_sym) begin
              dout_eop_d = byp_cur;
              state_d    = byp_cur ? StIdle : StParity;
              cnt_d      = 8'd0;
              par_d      = 6'd0;
            end else begin
              state_d = StData;
            end
          end
        end
        StParity: begin
          dout_d     = rem_q[0];
          dout_val_d = 1'b1;
          rem_d      = {8'h00, rem_q[R-1:1]};
          par_d      = par_q + 6'd1;
          if (par_q == ParLast) begin
            dout_eop_d = 1'b1;
            par_d      = 6'd0;
            state_d    = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State, remainder and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rem_q       <= '0;
      cnt_q       <= 8'd0;
      par_q       <= 6'd0;
      dout_q      <= 8'h00;
      dout_val_q  <= 1'b0;
      dout_sop_q  <= 1'b0;
      dout_eop_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      par_q       <= par_d;
      dout_q      <= dout_d;
      dout_val_q  <= dout_val_d;
      dout_sop_q  <= dout_sop_d;
      dout_eop_q  <= dout_eop_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule
